ysyx_mem_arbiter: RTL
=====================

Name: ysyx_mem_arbiter

Overview:
- Single AXI4 master-port scheduler that shares the core's one outbound memory bus between three requesters: IFU instruction-line refill (burst read), LSU load (single-beat read) and LSU store (single-beat write).
- Sits between the IFU/LSU request interfaces and the io_master_* AXI4 port at the core top.
- Allows one outstanding transaction. Arbitrates with a fixed-priority + round-robin policy.
- Supports IFU refill squash on bad speculation.

Parameters:
ADDR_W, 32, address width of requests and AXI addresses
IFU_BEATS, 4, beats per IFU refill burst (power of two, 1..16)
IFU_ID, 4'd0, AXI ID driven for IFU reads
LSU_ID, 4'd1, AXI ID driven for LSU reads/writes

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ifu_req_valid/ifu_req_ready  in/out  1/1  IFU refill request handshake
ifu_req_addr  in  ADDR_W  refill address
ifu_flush  in  1  squash pending/in-flight IFU refill (bad speculation)
ifu_resp_valid/ifu_resp_last/ifu_resp_err  out  1/1/1  IFU beat strobe, final beat, error on last
lsu_rd_valid/lsu_rd_ready  in/out  1/1  LSU load handshake
lsu_rd_addr/lsu_rd_size  in  ADDR_W/3  load address, AXI size code
lsu_rd_resp_valid/lsu_rd_err  out  1/1  load data strobe, error
resp_data  out  64  read data shared by IFU and LSU responses
lsu_wr_valid/lsu_wr_ready  in/out  1/1  LSU store handshake
lsu_wr_addr/lsu_wr_size/lsu_wr_data/lsu_wr_strb  in  ADDR_W/3/64/8  store payload
lsu_wr_done/lsu_wr_err  out  1/1  store completion pulse, error
m_ar{valid,ready,addr,id,len,size,burst}  out/in/out/out/out/out/out  1/1/ADDR_W/4/8/3/2  AXI AR
m_r{valid,ready,data,id,resp,last}  in/out/in/in/in/in  1/1/64/4/2/1  AXI R
m_aw{valid,ready,addr,id,len,size,burst}  out/in/out/out/out/out/out  1/1/ADDR_W/4/8/3/2  AXI AW
m_w{valid,ready,data,strb,last}  out/in/out/out/out  1/1/64/8/1  AXI W
m_b{valid,ready,id,resp}  in/out/in/in  1/1/4/2  AXI B

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr=0 (IFU favoured).
  - All valid/ready/done/err outputs 0.
  - Latched address/data regs 0.
  - A transaction in flight at reset is abandoned with no recovery.
- States: IDLE, AR, R, AWW, B.
- IDLE arbitration, in priority order:
  1. lsu_wr_valid -> AWW.
  2. Otherwise, among ifu_req_valid (gated by !ifu_flush) and lsu_rd_valid: if both are set, pick IFU when rr=0, else LSU. rr toggles after each read grant.
  3. If only one is set, grant it.
- Grant: the matching *_ready pulses 1 cycle; the request is latched; next state is AR or AWW.
- AR:
  - m_arvalid=1, held stable until m_arready; then go to R.
  - IFU: araddr = addr aligned down to IFU_BEATS*8 bytes, arlen=IFU_BEATS-1, arsize=3, arburst=INCR(01), arid=IFU_ID.
  - LSU: araddr=addr, arlen=0, arsize=lsu_rd_size, arburst=INCR, arid=LSU_ID.
- R:
  - m_rready=1; resp_data=m_rdata passes through combinationally.
  - IFU: ifu_resp_valid=m_rvalid unless squashed; ifu_resp_last=m_rlast.
  - LSU: lsu_rd_resp_valid=m_rvalid.
  - Error is sticky OR of (m_rresp!=0 or m_rid mismatch) across the burst, reported on the last-beat strobe.
  - m_rvalid&m_rlast -> IDLE; the error flag clears.
- Squash:
  - ifu_flush in AR or R for an IFU grant sets the squash flag.
  - Remaining beats are still drained (rready=1) with ifu_resp_valid forced 0.
  - Flag clears on return to IDLE.
- AWW:
  - m_awvalid and m_wvalid are both asserted on entry. Each drops independently on its own handshake.
  - m_wlast=1, awlen=0, awsize=lsu_wr_size, awburst=INCR, awid=LSU_ID.
  - Both handshakes complete -> B.
- B:
  - m_bready=1.
  - On m_bvalid: lsu_wr_done pulses 1 cycle; lsu_wr_err=(m_bresp!=0)|(m_bid!=LSU_ID). Go to IDLE.
- Requests arriving in non-IDLE states wait; ready stays 0.
- A requester's valid must hold until its ready.
- Earliest re-grant is the cycle after the response, which fixes the minimum read latency at 3 cycles for a zero-wait slave.

Test Plan:
1. IFU req addr 0x3000_0014 alone, slave zero-wait -> araddr 0x3000_0000, arlen=3, arsize=3, 4 ifu_resp_valid beats, last on 4th, err=0.
2. ifu_req_valid and lsu_rd_valid set in the same cycle twice in a row from reset -> IFU granted first, LSU second (rr alternation).
3. lsu_wr_valid together with both reads pending -> write granted first; awready delayed 3 cycles while wready is immediate -> wvalid drops first, lsu_wr_done pulses once after bvalid.
4. ifu_flush asserted after beat 1 of a 4-beat refill -> beats 2-4 drained with rready=1, no ifu_resp_valid; FSM reaches IDLE after rlast.
5. LSU load with rresp=2'b10 -> lsu_rd_resp_valid=1 with lsu_rd_err=1; next load with OKAY -> err=0.
6. rst asserted in R mid-burst -> next edge-free check: all valids 0, state IDLE, rr=0 immediately.

Source files
------------

// File: rtl/ysyx_mem_arbiter.sv
// Shares the core's single AXI4 master port between IFU line refills, LSU loads and LSU stores.
// One transaction in flight; stores win, contested reads alternate round-robin.
module ysyx_mem_arbiter #(
  parameter int         ADDR_W    = 32,
  parameter int         IFU_BEATS = 4,
  parameter logic [3:0] IFU_ID    = 4'd0,
  parameter logic [3:0] LSU_ID    = 4'd1
) (
  input  logic              clk,
  input  logic              rst,
  // IFU refill
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  input  logic              ifu_flush,
  output logic              ifu_resp_valid,
  output logic              ifu_resp_last,
  output logic              ifu_resp_err,
  // LSU load
  input  logic              lsu_rd_valid,
  output logic              lsu_rd_ready,
  input  logic [ADDR_W-1:0] lsu_rd_addr,
  input  logic [2:0]        lsu_rd_size,
  output logic              lsu_rd_resp_valid,
  output logic              lsu_rd_err,
  output logic [63:0]       resp_data,
  // LSU store
  input  logic              lsu_wr_valid,
  output logic              lsu_wr_ready,
  input  logic [ADDR_W-1:0] lsu_wr_addr,
  input  logic [2:0]        lsu_wr_size,
  input  logic [63:0]       lsu_wr_data,
  input  logic [7:0]        lsu_wr_strb,
  output logic              lsu_wr_done,
  output logic              lsu_wr_err,
  // AXI AR
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [3:0]        m_arid,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  // AXI R
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [63:0]       m_rdata,
  input  logic [3:0]        m_rid,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  // AXI AW
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [3:0]        m_awid,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  // AXI W
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [63:0]       m_wdata,
  output logic [7:0]        m_wstrb,
  output logic              m_wlast,
  // AXI B
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [3:0]        m_bid,
  input  logic [1:0]        m_bresp
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AWW  = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(IFU_BEATS * 8 - 1));
  localparam logic [7:0]        IFU_LEN   = 8'(IFU_BEATS - 1);
  localparam logic [1:0]        BURST_INCR = 2'b01;

  logic [2:0]        state_reg, state_next;
  logic              rr_reg;
  logic              owner_ifu_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [2:0]        size_reg;
  logic [63:0]       wdata_reg;
  logic [7:0]        wstrb_reg;
  logic              err_reg;
  logic              squash_reg;
  logic              aw_pend_reg;
  logic              w_pend_reg;

  logic idle, in_ar, in_r, in_aww, in_b;
  logic ifu_cand, pick_wr, pick_ifu, pick_lsu;
  logic r_beat, beat_err, err_total;
  logic [3:0] exp_rid;
  logic aw_ok, w_ok;

  // Grants are combinational in IDLE so the ready pulse lasts exactly one cycle.
  always_comb begin
    idle     = (state_reg == S_IDLE) & ~rst;
    in_ar    = (state_reg == S_AR);
    in_r     = (state_reg == S_R);
    in_aww   = (state_reg == S_AWW);
    in_b     = (state_reg == S_B);
    ifu_cand = ifu_req_valid & ~ifu_flush;
    pick_wr  = idle & lsu_wr_valid;
    pick_ifu = idle & ~lsu_wr_valid & ifu_cand & (~lsu_rd_valid | ~rr_reg);
    pick_lsu = idle & ~lsu_wr_valid & lsu_rd_valid & (~ifu_cand | rr_reg);
  end

  assign ifu_req_ready = pick_ifu;
  assign lsu_rd_ready  = pick_lsu;
  assign lsu_wr_ready  = pick_wr;

  always_comb begin
    exp_rid   = owner_ifu_reg ? IFU_ID : LSU_ID;
    r_beat    = in_r & m_rvalid;
    beat_err  = (m_rresp != 2'b00) | (m_rid != exp_rid);
    err_total = err_reg | beat_err;
    aw_ok     = ~aw_pend_reg | m_awready;
    w_ok      = ~w_pend_reg | m_wready;
  end

  // Read response side; a squashed refill still drains but never strobes the IFU.
  assign resp_data         = m_rdata;
  assign m_rready          = in_r;
  assign ifu_resp_valid    = r_beat & owner_ifu_reg & ~squash_reg & ~ifu_flush;
  assign ifu_resp_last     = ifu_resp_valid & m_rlast;
  assign ifu_resp_err      = ifu_resp_last & err_total;
  assign lsu_rd_resp_valid = r_beat & ~owner_ifu_reg;
  assign lsu_rd_err        = lsu_rd_resp_valid & err_total;

  assign m_arvalid = in_ar;
  assign m_araddr  = owner_ifu_reg ? (addr_reg & LINE_MASK) : addr_reg;
  assign m_arid    = owner_ifu_reg ? IFU_ID : LSU_ID;
  assign m_arlen   = owner_ifu_reg ? IFU_LEN : 8'd0;
  assign m_arsize  = owner_ifu_reg ? 3'd3 : size_reg;
  assign m_arburst = BURST_INCR;

  assign m_awvalid = in_aww & aw_pend_reg;
  assign m_awaddr  = addr_reg;
  assign m_awid    = LSU_ID;
  assign m_awlen   = 8'd0;
  assign m_awsize  = size_reg;
  assign m_awburst = BURST_INCR;
  assign m_wvalid  = in_aww & w_pend_reg;
  assign m_wdata   = wdata_reg;
  assign m_wstrb   = wstrb_reg;
  assign m_wlast   = 1'b1;

  assign m_bready    = in_b;
  assign lsu_wr_done = in_b & m_bvalid;
  assign lsu_wr_err  = lsu_wr_done & ((m_bresp != 2'b00) | (m_bid != LSU_ID));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (pick_wr)
          state_next = S_AWW;
        else if (pick_ifu | pick_lsu)
          state_next = S_AR;
      end
      S_AR:    if (m_arready) state_next = S_R;
      S_R:     if (m_rvalid & m_rlast) state_next = S_IDLE;
      S_AWW:   if (aw_ok & w_ok) state_next = S_B;
      S_B:     if (m_bvalid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      rr_reg        <= 1'b0;
      owner_ifu_reg <= 1'b0;
      addr_reg      <= '0;
      size_reg      <= 3'd0;
      wdata_reg     <= 64'd0;
      wstrb_reg     <= 8'd0;
      err_reg       <= 1'b0;
      squash_reg    <= 1'b0;
      aw_pend_reg   <= 1'b0;
      w_pend_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (pick_wr) begin
        addr_reg    <= lsu_wr_addr;
        size_reg    <= lsu_wr_size;
        wdata_reg   <= lsu_wr_data;
        wstrb_reg   <= lsu_wr_strb;
        aw_pend_reg <= 1'b1;
        w_pend_reg  <= 1'b1;
      end else if (pick_ifu) begin
        addr_reg      <= ifu_req_addr;
        size_reg      <= 3'd3;
        owner_ifu_reg <= 1'b1;
        rr_reg        <= ~rr_reg;
      end else if (pick_lsu) begin
        addr_reg      <= lsu_rd_addr;
        size_reg      <= lsu_rd_size;
        owner_ifu_reg <= 1'b0;
        rr_reg        <= ~rr_reg;
      end

      if (in_aww) begin
        if (m_awready) aw_pend_reg <= 1'b0;
        if (m_wready)  w_pend_reg  <= 1'b0;
      end

      // Error accumulates across the burst and is forgotten once the last beat is out.
      if (idle)
        err_reg <= 1'b0;
      else if (r_beat)
        err_reg <= m_rlast ? 1'b0 : err_total;

      if (idle || (r_beat && m_rlast))
        squash_reg <= 1'b0;
      else if ((in_ar | in_r) & owner_ifu_reg & ifu_flush)
        squash_reg <= 1'b1;
    end
  end

endmodule
